cam_dvp_capture: RTL and testbench
==================================

# cam_dvp_capture

Receive side of the camera interface: after the sensor has been configured over I2C, this block samples the camera's parallel DVP bus (CAM_VS, CAM_HS/HREF, CAM_D[7:0]) on the camera pixel clock CAM_PLK. It pairs bytes into RGB565 pixels and emits a pixel stream with coordinates and a linear frame-buffer write address. It sits between the GPIO_0 camera pins and the frame buffer that feeds the HDMI output path, and it flags malformed lines and frames.

## Interface
- H_ACTIVE, 640, active pixels per line (2 bytes each)
- V_ACTIVE, 480, active lines per frame
- SKIP_FRAMES, 2, complete frames discarded after reset or enable rise (sensor settling)
- VS_ACTIVE_HIGH, 1, 1: vsync pulse is high; 0: inverted
- X_W / Y_W / ADDR_W, 10 / 9 / 19, $clog2(H_ACTIVE) / $clog2(V_ACTIVE) / $clog2(H_ACTIVE*V_ACTIVE)

Ports:
- clk  in  1  camera pixel clock (CAM_PLK); the only clock
- reset  in  1  asynchronous, active-high
- enable  in  1  capture arm, quasi-static; sampled only at frame start
- cam_vs  in  1  frame sync
- cam_hs  in  1  HREF, high during active bytes
- cam_d  in  8  pixel byte
- pix_valid  out  1  pix_data, pix_x, pix_y and wr_addr valid this cycle
- pix_data  out  16  RGB565; first byte is [15:8], second byte is [7:0]
- pix_x  out  X_W  column, 0..H_ACTIVE-1
- pix_y  out  Y_W  row, 0..V_ACTIVE-1
- wr_addr  out  ADDR_W  pix_y*H_ACTIVE + pix_x
- sof  out  1  high with pixel (0,0) only
- frame_done  out  1  1-cycle pulse at the end of each captured frame
- line_err  out  1  1-cycle pulse for a bad line
- frame_err  out  1  1-cycle pulse for a bad frame
- frame_cnt  out  8  captured frames; wraps 255->0

## Operation
- Input stage: cam_vs, cam_hs and cam_d are registered once. Edges are detected on the registered copies. vs_act = cam_vs_q XNOR VS_ACTIVE_HIGH.
- States:
  - IDLE (after reset): wait for vs_act rise -> SYNC.
  - SYNC: on vs_act fall:
    - skip_cnt>0: decrement skip_cnt, stay in SYNC for the next frame.
    - otherwise, if enable=1: -> ACTIVE, and clear x, y and line_base.
    - otherwise: stay in SYNC.
  - ACTIVE: capture. On vs_act rise -> frame end, then -> SYNC.
- skip_cnt reloads to SKIP_FRAMES on reset and on every enable 0->1 transition.
- Byte pairing: while cam_hs_q=1, a phase bit toggles each cycle. Phase 0 latches the high byte. Phase 1 forms the pixel, and the output register updates on the next edge.
- Line end (cam_hs_q fall):
  - If byte count != 2*H_ACTIVE, pulse line_err. An odd trailing byte is dropped.
  - Then x=0, y+1, line_base += H_ACTIVE.
- Bounds:
  - Pixels with x>=H_ACTIVE are suppressed (no pix_valid); line_err pulses once at line end.
  - Lines with y>=V_ACTIVE are suppressed; frame_err pulses at frame end.
- Frame end (vs_act rise while in ACTIVE):
  - pulse frame_done and increment frame_cnt.
  - pulse frame_err if lines != V_ACTIVE.
  - If cam_hs_q=1 at that moment, the line is aborted and both line_err and frame_err pulse.
- wr_addr = line_base + x. Computed with an adder only; no multiplier.
- Reset mid-frame: all state clears and the block returns to IDLE. The first frame after reset is never captured, because a full vsync pulse must be seen first.

## Timing
- Reset values: every output is 0. frame_cnt=0; skip_cnt=SKIP_FRAMES.
- Latency: pix_valid is high in the cycle after edge k+1, where edge k samples the second byte on the pins. That is 2 clk from pins to output.
- pix_valid occurs at most once per 2 cycles. There is no back-pressure: the downstream write must accept 1 pixel per 2 clk.
- frame_done, line_err and frame_err are registered and appear 2 clk after the causing pin edge.
- sof coincides with pix_valid of pixel (0,0) only.
- line_err and frame_err in the same cycle are legal.

## Structure
- Package cam_pkg holds:
  - the state enum (IDLE, SYNC, ACTIVE);
  - the rgb565_t struct;
  - default resolution constants (640x480).
- Sub-module dvp_sync_detect: the input register plus rise/fall detection for vs_act and cam_hs. The counters and FSM live in cam_dvp_capture.

## Test plan
- Nominal: SKIP_FRAMES=0, 4x3 frame (H_ACTIVE=4, V_ACTIVE=3), bytes 0x01..0x18.
  - Expect 12 pix_valid with pix_data 0x0102, 0x0304, ...
  - wr_addr 0..11; sof with 0x0102 only; one frame_done; frame_cnt=1; no errors.
- Skip: SKIP_FRAMES=2, send 3 frames. Only frame 3 produces pix_valid; frame_cnt=1.
- Short/long lines: H_ACTIVE=4.
  - Line of 7 bytes -> 3 pixels, line_err=1.
  - Line of 10 bytes -> 4 pixels, line_err=1.
  - The next line still starts at wr_addr=line_base.
- Frame errors:
  - 2 lines with V_ACTIVE=3 -> frame_err at vsync.
  - vsync rising mid-HREF -> line_err and frame_err in the same cycle.
- Reset mid-line: assert reset after pixel 5.
  - Outputs go 0 at once.
  - The partial next frame is ignored; capture resumes at the following vsync with pix_x=0, pix_y=0.
- VS_ACTIVE_HIGH=0 with an inverted vsync gives output identical to the nominal case.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: shared types and default resolution for the DVP camera capture path.
package cam_pkg;

  // Capture FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } cam_state_t;

  // One RGB565 pixel; the first DVP byte lands in the upper half
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Default sensor window
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

endpackage

// File: rtl/dvp_sync_detect.sv
// dvp_sync_detect: registers the raw DVP pins once and derives sync edges
// from the registered copies, normalising vsync polarity to active-high.
module dvp_sync_detect #(
  parameter bit VS_ACTIVE_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cam_vs,
  input  logic       cam_hs,
  input  logic [7:0] cam_d,
  output logic       cam_hs_q,
  output logic [7:0] cam_d_q,
  output logic       vs_rise,
  output logic       vs_fall,
  output logic       hs_fall
);

  logic cam_vs_q;
  logic vs_act;
  logic vs_act_prev_reg;
  logic hs_prev_reg;

  // vsync pulse expressed as active-high regardless of sensor polarity
  assign vs_act = ~(cam_vs_q ^ VS_ACTIVE_HIGH);

  // Pin register plus one cycle of history; vsync resets to its idle level
  // so releasing reset never looks like a sync edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cam_vs_q        <= ~VS_ACTIVE_HIGH;
      cam_hs_q        <= 1'b0;
      cam_d_q         <= 8'd0;
      vs_act_prev_reg <= 1'b0;
      hs_prev_reg     <= 1'b0;
    end else begin
      cam_vs_q        <= cam_vs;
      cam_hs_q        <= cam_hs;
      cam_d_q         <= cam_d;
      vs_act_prev_reg <= vs_act;
      hs_prev_reg     <= cam_hs_q;
    end
  end

  assign vs_rise = vs_act & ~vs_act_prev_reg;
  assign vs_fall = ~vs_act & vs_act_prev_reg;
  assign hs_fall = ~cam_hs_q & hs_prev_reg;

endmodule

// File: rtl/cam_dvp_capture.sv
// cam_dvp_capture: DVP receive path. Pairs bytes into RGB565 pixels, tracks
// column/row and a linear write address, and flags malformed lines/frames.
module cam_dvp_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE       = H_ACTIVE_DEF,
  parameter int V_ACTIVE       = V_ACTIVE_DEF,
  parameter int SKIP_FRAMES    = 2,
  parameter bit VS_ACTIVE_HIGH = 1'b1,
  parameter int X_W            = $clog2(H_ACTIVE),
  parameter int Y_W            = $clog2(V_ACTIVE),
  parameter int ADDR_W         = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cam_vs,
  input  logic              cam_hs,
  input  logic [7:0]        cam_d,
  output logic              pix_valid,
  output logic [15:0]       pix_data,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              sof,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  // Counters carry one spare bit so overlong lines/frames saturate just past
  // the limit instead of wrapping back into the valid window.
  localparam logic [X_W:0]        X_LIM      = (X_W+1)'(H_ACTIVE);
  localparam logic [X_W:0]        X_ONE      = (X_W+1)'(1);
  localparam logic [X_W+1:0]      BYTES_LINE = (X_W+2)'(2 * H_ACTIVE);
  localparam logic [X_W+1:0]      BC_SAT     = (X_W+2)'(2 * H_ACTIVE + 1);
  localparam logic [X_W+1:0]      BC_ONE     = (X_W+2)'(1);
  localparam logic [Y_W:0]        Y_LIM      = (Y_W+1)'(V_ACTIVE);
  localparam logic [Y_W:0]        Y_SAT      = (Y_W+1)'(V_ACTIVE + 1);
  localparam logic [Y_W:0]        Y_ONE      = (Y_W+1)'(1);
  localparam logic [ADDR_W-1:0]   H_STEP     = ADDR_W'(H_ACTIVE);
  localparam logic [7:0]          SKIP_INIT  = 8'(SKIP_FRAMES);

  logic       cam_hs_q;
  logic [7:0] cam_d_q;
  logic       vs_rise, vs_fall, hs_fall;

  dvp_sync_detect #(.VS_ACTIVE_HIGH(VS_ACTIVE_HIGH)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .cam_vs   (cam_vs),
    .cam_hs   (cam_hs),
    .cam_d    (cam_d),
    .cam_hs_q (cam_hs_q),
    .cam_d_q  (cam_d_q),
    .vs_rise  (vs_rise),
    .vs_fall  (vs_fall),
    .hs_fall  (hs_fall)
  );

  cam_state_t          state_reg, state_next;
  logic                phase_reg;
  logic [7:0]          hi_reg;
  logic [X_W+1:0]      byte_cnt_reg;
  logic [X_W:0]        x_reg;
  logic [Y_W:0]        y_reg;
  logic [ADDR_W-1:0]   line_base_reg;
  logic [7:0]          skip_cnt_reg;
  logic                enable_prev_reg;

  logic                frame_end, line_end, capture_start, skip_dec;
  logic                pix_form, pix_valid_next, line_err_next, frame_err_next;
  logic [Y_W:0]        lines_seen;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next state: a full vsync pulse must be seen before any capture starts
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (vs_rise) state_next = SYNC;
      SYNC:    if (vs_fall && skip_cnt_reg == 8'd0 && enable) state_next = ACTIVE;
      ACTIVE:  if (vs_rise) state_next = SYNC;
      default: state_next = IDLE;
    endcase
  end

  // Decode of per-cycle events; a line ending in the same cycle as vsync still counts
  always_comb begin
    frame_end      = (state_reg == ACTIVE) && vs_rise;
    line_end       = (state_reg == ACTIVE) && hs_fall;
    capture_start  = (state_reg == SYNC) && (state_next == ACTIVE);
    skip_dec       = (state_reg == SYNC) && vs_fall && (skip_cnt_reg != 8'd0);
    pix_form       = (state_reg == ACTIVE) && cam_hs_q && phase_reg;
    pix_valid_next = pix_form && (x_reg < X_LIM) && (y_reg < Y_LIM);
    lines_seen     = (hs_fall && y_reg != Y_SAT) ? y_reg + Y_ONE : y_reg;
    line_err_next  = (line_end && byte_cnt_reg != BYTES_LINE) || (frame_end && cam_hs_q);
    frame_err_next = frame_end && (cam_hs_q || lines_seen != Y_LIM);
  end

  // Byte pairing and per-line byte count; phase restarts on every line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_reg    <= 1'b0;
      hi_reg       <= 8'd0;
      byte_cnt_reg <= '0;
    end else begin
      phase_reg <= cam_hs_q ? ~phase_reg : 1'b0;
      if (cam_hs_q && !phase_reg) hi_reg <= cam_d_q;
      if (!cam_hs_q)                  byte_cnt_reg <= '0;
      else if (byte_cnt_reg != BC_SAT) byte_cnt_reg <= byte_cnt_reg + BC_ONE;
    end
  end

  // Position tracking; the row base advances by addition so no multiplier is needed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg         <= '0;
      y_reg         <= '0;
      line_base_reg <= '0;
    end else if (capture_start) begin
      x_reg         <= '0;
      y_reg         <= '0;
      line_base_reg <= '0;
    end else if (line_end) begin
      x_reg         <= '0;
      line_base_reg <= line_base_reg + H_STEP;
      if (y_reg != Y_SAT) y_reg <= y_reg + Y_ONE;
    end else if (pix_form && x_reg != X_LIM) begin
      x_reg <= x_reg + X_ONE;
    end
  end

  // Settling-frame skip counter and captured-frame counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_cnt_reg    <= SKIP_INIT;
      enable_prev_reg <= 1'b0;
      frame_cnt       <= 8'd0;
    end else begin
      enable_prev_reg <= enable;
      if (enable && !enable_prev_reg) skip_cnt_reg <= SKIP_INIT;
      else if (skip_dec)              skip_cnt_reg <= skip_cnt_reg - 8'd1;
      if (frame_end) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Registered pixel stream and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid  <= 1'b0;
      pix_data   <= 16'd0;
      pix_x      <= '0;
      pix_y      <= '0;
      wr_addr    <= '0;
      sof        <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      pix_valid  <= pix_valid_next;
      sof        <= pix_valid_next && x_reg == '0 && y_reg == '0;
      frame_done <= frame_end;
      line_err   <= line_err_next;
      frame_err  <= frame_err_next;
      if (pix_valid_next) begin
        pix_data <= rgb565_t'({hi_reg, cam_d_q});
        pix_x    <= x_reg[X_W-1:0];
        pix_y    <= y_reg[Y_W-1:0];
        wr_addr  <= line_base_reg + ADDR_W'(x_reg[X_W-1:0]);
      end
    end
  end

endmodule

// File: tb/tb_cam_dvp_capture.sv
// tb_cam_dvp_capture: three 4x3 instances (nominal, two skipped frames,
// inverted vsync) share the DVP pins; only the selected one is out of reset.
// Expected events are queued as stimulus is issued and a negedge monitor
// pops and compares every cycle the selected DUT shows an output event.
module tb_cam_dvp_capture;

  localparam int H = 4;
  localparam int V = 3;

  typedef struct packed {
    logic        pv;
    logic [15:0] data;
    logic [1:0]  x;
    logic [1:0]  y;
    logic [3:0]  addr;
    logic        sof;
    logic        fd;
    logic        le;
    logic        fe;
    logic [7:0]  fcnt;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic       enable;
  logic       cam_vs, cam_hs;
  logic [7:0] cam_d;

  logic        pv   [3];
  logic [15:0] pd   [3];
  logic [1:0]  px   [3];
  logic [1:0]  py   [3];
  logic [3:0]  wa   [3];
  logic        sf   [3];
  logic        fd   [3];
  logic        le   [3];
  logic        fe   [3];
  logic [7:0]  fc_o [3];

  cam_dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(0), .VS_ACTIVE_HIGH(1'b1)) dut_a (
    .clk(clk), .reset(rst_a), .enable(enable), .cam_vs(cam_vs), .cam_hs(cam_hs), .cam_d(cam_d),
    .pix_valid(pv[0]), .pix_data(pd[0]), .pix_x(px[0]), .pix_y(py[0]), .wr_addr(wa[0]),
    .sof(sf[0]), .frame_done(fd[0]), .line_err(le[0]), .frame_err(fe[0]), .frame_cnt(fc_o[0]));

  cam_dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2), .VS_ACTIVE_HIGH(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .enable(enable), .cam_vs(cam_vs), .cam_hs(cam_hs), .cam_d(cam_d),
    .pix_valid(pv[1]), .pix_data(pd[1]), .pix_x(px[1]), .pix_y(py[1]), .wr_addr(wa[1]),
    .sof(sf[1]), .frame_done(fd[1]), .line_err(le[1]), .frame_err(fe[1]), .frame_cnt(fc_o[1]));

  cam_dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(0), .VS_ACTIVE_HIGH(1'b0)) dut_c (
    .clk(clk), .reset(rst_c), .enable(enable), .cam_vs(~cam_vs), .cam_hs(cam_hs), .cam_d(cam_d),
    .pix_valid(pv[2]), .pix_data(pd[2]), .pix_x(px[2]), .pix_y(py[2]), .wr_addr(wa[2]),
    .sof(sf[2]), .frame_done(fd[2]), .line_err(le[2]), .frame_err(fe[2]), .frame_cnt(fc_o[2]));

  int         tests = 0;
  int         fails = 0;
  int         sel   = 0;
  logic [7:0] fc    = 8'd0;
  logic [7:0] bval  = 8'd1;
  obs_t       exp_q [$];
  obs_t       mon_got, mon_exp;

  // Scoreboard monitor: one line per observed transaction
  always @(negedge clk) begin
    mon_got = '{pv: pv[sel], data: pd[sel], x: px[sel], y: py[sel], addr: wa[sel],
                sof: sf[sel], fd: fd[sel], le: le[sel], fe: fe[sel], fcnt: fc_o[sel]};
    if (mon_got.pv || mon_got.fd || mon_got.le || mon_got.fe) begin
      if (!mon_got.pv) begin
        mon_got.data = '0; mon_got.x = '0; mon_got.y = '0; mon_got.addr = '0;
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event dut%0d got=%h required=none", sel, mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          fails++;
          $display("FAIL scoreboard dut%0d got=%h required=%h", sel, mon_got, mon_exp);
        end else begin
          $display("[TB] dut%0d pv=%0b data=%h x=%0d y=%0d addr=%0d sof=%0b fd=%0b le=%0b fe=%0b fcnt=%0d",
                   sel, mon_got.pv, mon_got.data, mon_got.x, mon_got.y, mon_got.addr,
                   mon_got.sof, mon_got.fd, mon_got.le, mon_got.fe, mon_got.fcnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cam_hs = 1'b0;
    cam_d  = 8'd0;
    repeat (n) tick();
  endtask

  task automatic check_zero(input int k, input string name);
    logic [41:0] all;
    all = {pv[k], pd[k], px[k], py[k], wa[k], sf[k], fd[k], le[k], fe[k], fc_o[k]};
    tests++;
    if (all !== '0) begin
      fails++;
      $display("FAIL %s dut%0d got=%h required=0", name, k, all);
    end else begin
      $display("[TB] %s dut%0d outputs all zero", name, k);
    end
  endtask

  task automatic push_pix(input logic [7:0] hi, input logic [7:0] lo, input int x, input int y);
    obs_t e;
    e      = '0;
    e.pv   = 1'b1;
    e.data = {hi, lo};
    e.x    = 2'(x);
    e.y    = 2'(y);
    e.addr = 4'(y * H + x);
    e.sof  = (x == 0 && y == 0);
    e.fcnt = fc;
    exp_q.push_back(e);
  endtask

  task automatic push_evt(input bit f_done, input bit l_err, input bit f_err);
    obs_t e;
    if (f_done) fc = fc + 8'd1;
    e      = '0;
    e.fd   = f_done;
    e.le   = l_err;
    e.fe   = f_err;
    e.fcnt = fc;
    exp_q.push_back(e);
  endtask

  // One HREF line of nbytes; when captured, row gives the expected pix_y
  task automatic send_line(input int nbytes, input bit cap, input int row);
    logic [7:0] b0;
    b0 = bval;
    if (cap) begin
      for (int p = 0; p < nbytes / 2; p++)
        if (p < H) push_pix(b0 + 8'(2 * p), b0 + 8'(2 * p + 1), p, row);
      if (nbytes != 2 * H) push_evt(1'b0, 1'b1, 1'b0);
    end
    cam_hs = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      cam_d = bval;
      bval  = bval + 8'd1;
      tick();
    end
    idle(3);
  endtask

  task automatic send_frame(input bit cap, input int nlines);
    for (int r = 0; r < nlines; r++) send_line(2 * H, cap, r);
  endtask

  // Full vsync pulse; ends_frame when it closes a captured frame
  task automatic vsync(input bit ends_frame, input bit f_err);
    if (ends_frame) push_evt(1'b1, 1'b0, f_err);
    cam_hs = 1'b0;
    cam_vs = 1'b1;
    repeat (3) tick();
    cam_vs = 1'b0;
    repeat (4) tick();
  endtask

  // Line cut off by vsync rising while HREF is still high
  task automatic abort_line(input int row);
    push_pix(bval, bval + 8'd1, 0, row);
    push_evt(1'b1, 1'b1, 1'b1);
    cam_hs = 1'b1;
    cam_d = bval; bval = bval + 8'd1; tick();
    cam_d = bval; bval = bval + 8'd1; tick();
    cam_vs = 1'b1;
    cam_d = bval; bval = bval + 8'd1; tick();
    cam_hs = 1'b0;
    repeat (3) tick();
    cam_vs = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    enable = 1'b1; cam_vs = 1'b0; cam_hs = 1'b0; cam_d = 8'd0;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) check_zero(k, "reset_state");

    // Nominal 4x3 frame, bytes 0x01..0x18
    rst_a = 1'b0;
    idle(4);
    bval = 8'd1;
    vsync(1'b0, 1'b0);
    send_frame(1'b1, 3);
    vsync(1'b1, 1'b0);

    // Short (7 bytes) and long (10 bytes) lines, then a clean line
    send_line(7, 1'b1, 0);
    send_line(10, 1'b1, 1);
    send_line(8, 1'b1, 2);
    vsync(1'b1, 1'b0);

    // Too few lines
    send_line(8, 1'b1, 0);
    send_line(8, 1'b1, 1);
    vsync(1'b1, 1'b1);

    // Too many lines: the fourth is suppressed
    send_frame(1'b1, 3);
    send_line(8, 1'b0, 3);
    vsync(1'b1, 1'b1);

    // vsync rising mid-HREF
    send_line(8, 1'b1, 0);
    abort_line(1);

    // Reset after pixel 5 of a captured frame
    send_line(8, 1'b1, 0);
    push_pix(bval, bval + 8'd1, 0, 1);
    push_pix(bval + 8'd2, bval + 8'd3, 1, 1);
    cam_hs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cam_d = bval;
      bval  = bval + 8'd1;
      tick();
    end
    cam_d = bval;
    bval  = bval + 8'd1;
    #6;
    rst_a = 1'b1;
    #1;
    check_zero(0, "async_reset_mid_line");
    fc = 8'd0;
    tick();
    idle(2);
    rst_a = 1'b0;
    idle(3);
    send_line(8, 1'b0, 0);
    vsync(1'b0, 1'b0);
    send_frame(1'b1, 3);
    vsync(1'b1, 1'b0);
    idle(4);

    // Two settling frames skipped, third captured
    rst_a = 1'b1;
    sel = 1;
    fc = 8'd0;
    rst_b = 1'b0;
    idle(4);
    vsync(1'b0, 1'b0);
    send_frame(1'b0, 3);
    vsync(1'b0, 1'b0);
    send_frame(1'b0, 3);
    vsync(1'b0, 1'b0);
    send_frame(1'b1, 3);
    vsync(1'b1, 1'b0);
    idle(4);

    // Inverted vsync polarity, same expectations as nominal
    rst_b = 1'b1;
    sel = 2;
    fc = 8'd0;
    rst_c = 1'b0;
    idle(4);
    bval = 8'd1;
    vsync(1'b0, 1'b0);
    send_frame(1'b1, 3);
    vsync(1'b1, 1'b0);
    idle(6);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_events got=%0d_pending required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
